// File: rtl/gates_pkg.sv
// Shared types and helpers for the registered reduction-gate block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   GATES_WIDTH - default number of input bits reduced
//   RED_MAX_W   - widest vector the reduce() helper accepts
//   red_op_e    - base reduction selector (AND / OR / XOR)
//   reduce()    - reduction of the low 'width' bits of a zero-extended vector
package gates_pkg;

   localparam int GATES_WIDTH = 4;
   localparam int RED_MAX_W   = 64;

   typedef enum logic [1:0] {
      RED_AND = 2'd0,
      RED_OR  = 2'd1,
      RED_XOR = 2'd2
   } red_op_e;

   // Bits at or above 'width' are ignored, so the padding value of the
   // zero-extended vector never affects the result (AND would otherwise
   // see the padding zeros).
   function automatic logic reduce(input red_op_e                op,
                                   input logic [RED_MAX_W-1:0]   vec,
                                   input int                     width);
      logic r;
      r = (op == RED_AND);
      for (int i = 0; i < RED_MAX_W; i++) begin
         if (i < width) begin
            case (op)
               RED_AND: r = r & vec[i];
               RED_OR:  r = r | vec[i];
               RED_XOR: r = r ^ vec[i];
               default: r = 1'b0;
            endcase
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/gates_reduce.sv
// Purely combinational AND/OR/XOR reduction of one input vector.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows input continuously.
//
// Ports:
//   i_vec [WIDTH-1:0] - vector to reduce
//   o_and             - all bits 1
//   o_or              - any bit 1
//   o_xor             - odd number of ones
module gates_reduce
   import gates_pkg::*;
#(
   parameter int WIDTH = GATES_WIDTH
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic             o_and,
   output logic             o_or,
   output logic             o_xor
);

   generate
      if (WIDTH <= RED_MAX_W) begin : g_fn
         logic [RED_MAX_W-1:0] w_vec_ext;

         assign w_vec_ext = RED_MAX_W'(i_vec);
         assign o_and     = reduce(RED_AND, w_vec_ext, WIDTH);
         assign o_or      = reduce(RED_OR,  w_vec_ext, WIDTH);
         assign o_xor     = reduce(RED_XOR, w_vec_ext, WIDTH);
      end else begin : g_op
         // Wider than the helper handles: plain reduction operators.
         assign o_and = &i_vec;
         assign o_or  = |i_vec;
         assign o_xor = ^i_vec;
      end
   endgenerate

endmodule

// File: rtl/gates.sv
// Registered WIDTH-input reduction gates (AND/OR/XOR and complements).
// Latency: 2 cycles with REG_IN=1, 1 cycle with REG_IN=0.
// Backpressure: none; accepts a new vector every cycle, never stalls.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears input and output registers
//   a      - input vector, a[WIDTH-1] is the MSB
//   y      - AND reduction        y_nand - NAND reduction
//   y_or   - OR reduction         y_nor  - NOR reduction
//   y_xor  - XOR (odd parity)     y_xnor - XNOR (even parity)
module gates
   import gates_pkg::*;
#(
   parameter int WIDTH  = GATES_WIDTH,
   parameter bit REG_IN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   output logic             y,
   output logic             y_or,
   output logic             y_xor,
   output logic             y_nand,
   output logic             y_nor,
   output logic             y_xnor
);

   logic [WIDTH-1:0] w_sample;
   logic             w_and;
   logic             w_or;
   logic             w_xor;

   logic r_y;
   logic r_y_or;
   logic r_y_xor;
   logic r_y_nand;
   logic r_y_nor;
   logic r_y_xnor;

   generate
      if (REG_IN) begin : g_reg_in
         logic [WIDTH-1:0] r_a_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a_q <= '0;
            end else begin
               r_a_q <= a;
            end
         end

         assign w_sample = r_a_q;
      end else begin : g_no_reg_in
         assign w_sample = a;
      end
   endgenerate

   gates_reduce #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .i_vec (w_sample),
      .o_and (w_and),
      .o_or  (w_or),
      .o_xor (w_xor)
   );

   // Complements come from the same sample as the base reductions so the
   // six outputs are always mutually consistent. Reset value is 0 for all
   // six, including the complements, rather than the reduction of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y      <= 1'b0;
         r_y_or   <= 1'b0;
         r_y_xor  <= 1'b0;
         r_y_nand <= 1'b0;
         r_y_nor  <= 1'b0;
         r_y_xnor <= 1'b0;
      end else begin
         r_y      <= w_and;
         r_y_or   <= w_or;
         r_y_xor  <= w_xor;
         r_y_nand <= ~w_and;
         r_y_nor  <= ~w_or;
         r_y_xnor <= ~w_xor;
      end
   end

   assign y      = r_y;
   assign y_or   = r_y_or;
   assign y_xor  = r_y_xor;
   assign y_nand = r_y_nand;
   assign y_nor  = r_y_nor;
   assign y_xnor = r_y_xnor;

endmodule

// File: tb/tb_gates.sv
// Bench for gates: REG_IN=1 instance (dut) and REG_IN=0 instance (dut0)
// share clk, rst_n and a. Expected output words are queued when a vector is
// driven, tagged with the cycle they must appear, and popped on that cycle.
module tb_gates;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;

   logic y1, yor1, yxor1, ynand1, ynor1, yxnor1;
   logic y0, yor0, yxor0, ynand0, ynor0, yxnor0;
   logic [5:0] out1;
   logic [5:0] out0;

   assign out1 = {y1, yor1, yxor1, ynand1, ynor1, yxnor1};
   assign out0 = {y0, yor0, yxor0, ynand0, ynor0, yxnor0};

   gates #(.WIDTH(4), .REG_IN(1'b1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .y      (y1),
      .y_or   (yor1),
      .y_xor  (yxor1),
      .y_nand (ynand1),
      .y_nor  (ynor1),
      .y_xnor (yxnor1)
   );

   gates #(.WIDTH(4), .REG_IN(1'b0)) dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .y      (y0),
      .y_or   (yor0),
      .y_xor  (yxor0),
      .y_nand (ynand0),
      .y_nor  (ynor0),
      .y_xnor (yxnor0)
   );

   typedef struct {
      logic [3:0] v;
      logic [5:0] exp;
      int         due;
   } sb_t;

   sb_t q[$];
   sb_t q0[$];
   int  cyc;
   int  n_chk;
   int  n_fail;
   bit  trk0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: count ones, then derive each function from the count.
   function automatic logic [5:0] model(input logic [3:0] v);
      int   ones;
      logic an, o, x;
      ones = 0;
      for (int i = 0; i < 4; i++) if (v[i]) ones++;
      an = (ones == 4);
      o  = (ones != 0);
      x  = ones[0];
      return {an, o, x, ~an, ~o, ~x};
   endfunction

   // Drive one vector at the falling edge, optionally record what it must
   // produce, and return 1 time unit after the following rising edge.
   task automatic tick(input logic [3:0] v, input bit push);
      sb_t e;
      @(negedge clk);
      a = v;
      if (push) begin
         e.v = v; e.exp = model(v); e.due = cyc + 2;
         q.push_back(e);
         if (trk0) begin
            e.due = cyc + 1;
            q0.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      a     = 4'b1111;
      #3;
      n_chk++;
      if (out1 !== 6'b0) begin
         n_fail++; $display("FAIL reset_por dut got %b want 000000", out1);
      end
      n_chk++;
      if (out0 !== 6'b0) begin
         n_fail++; $display("FAIL reset_por dut0 got %b want 000000", out0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_async_reset;
      sb_t e;
      trk0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(4'b1111, 1'b1);
         while (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front(); n_chk++;
            if (out1 !== e.exp) begin
               n_fail++; $display("FAIL async_pre a=%b got %b want %b", e.v, out1, e.exp);
            end
         end
      end
      // Mid-cycle, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (out1 !== 6'b0) begin
         n_fail++; $display("FAIL async_reset dut got %b want 000000", out1);
      end
      n_chk++;
      if (out0 !== 6'b0) begin
         n_fail++; $display("FAIL async_reset dut0 got %b want 000000", out0);
      end
      q.delete();
      q0.delete();
      // Release with a=0 so the first post-release edge captures 0000.
      @(negedge clk);
      a = 4'b0000;
      rst_n = 1'b1;
      tick(4'b0000, 1'b0);
      tick(4'b0000, 1'b0);
      n_chk++;
      if (out1 !== model(4'b0000)) begin
         n_fail++; $display("FAIL async_recover got %b want %b", out1, model(4'b0000));
      end
   endtask

   task automatic test_walk;
      sb_t        e;
      logic [3:0] vecs [5] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      trk0 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k < 5) tick(vecs[k], 1'b1);
         else       tick(4'b0000, 1'b0);
         while (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front(); n_chk++;
            if (out1 !== e.exp) begin
               n_fail++; $display("FAIL walk a=%b got %b want %b", e.v, out1, e.exp);
            end
         end
      end
   endtask

   task automatic test_ones;
      sb_t e;
      trk0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       tick(4'b1111, 1'b1);
            1:       tick(4'b1101, 1'b1);
            default: tick(4'b0000, 1'b0);
         endcase
         while (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front(); n_chk++;
            if (out1 !== e.exp) begin
               n_fail++; $display("FAIL ones a=%b got %b want %b", e.v, out1, e.exp);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      sb_t e;
      int  n_y;
      n_y  = 0;
      trk0 = 1'b1;
      for (int k = 0; k < 18; k++) begin
         if (k < 16) tick(4'(k), 1'b1);
         else        tick(4'b0000, 1'b0);
         if (y1 === 1'b1) n_y++;
         while (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front(); n_chk++;
            if (out1 !== e.exp) begin
               n_fail++; $display("FAIL sweep dut a=%b got %b want %b", e.v, out1, e.exp);
            end
         end
         while (q0.size() != 0 && q0[0].due == cyc) begin
            e = q0.pop_front(); n_chk++;
            if (out0 !== e.exp) begin
               n_fail++; $display("FAIL sweep dut0 a=%b got %b want %b", e.v, out0, e.exp);
            end
         end
      end
      n_chk++;
      if (n_y !== 1) begin
         n_fail++; $display("FAIL sweep_y_count got %0d want 1", n_y);
      end
   endtask

   task automatic test_reset_midstream;
      sb_t e;
      trk0 = 1'b0;
      tick(4'b1100, 1'b0);          // 1100 now held in the input register
      @(negedge clk);
      a = 4'b1010;
      #1;
      rst_n = 1'b0;                 // both 1100 and 1010 are discarded
      #1;
      n_chk++;
      if (out1 !== 6'b0) begin
         n_fail++; $display("FAIL mid_reset got %b want 000000", out1);
      end
      q.delete();
      @(posedge clk);
      #1;
      n_chk++;
      if (out1 !== 6'b0) begin
         n_fail++; $display("FAIL mid_reset_hold got %b want 000000", out1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a     = 4'b1011;
      // First edge after release shows the cleared input register, the
      // second shows 1011.
      e.v = 4'b0000; e.exp = model(4'b0000); e.due = cyc + 1; q.push_back(e);
      e.v = 4'b1011; e.exp = model(4'b1011); e.due = cyc + 2; q.push_back(e);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick(4'b0000, 1'b0);
         while (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front(); n_chk++;
            if (out1 !== e.exp) begin
               n_fail++; $display("FAIL post_reset a=%b got %b want %b", e.v, out1, e.exp);
            end
            if (e.v == 4'b1011) begin
               n_chk++;
               if (yxor1 !== 1'b1) begin
                  n_fail++; $display("FAIL post_reset_xor got %b want 1", yxor1);
               end
            end
         end
      end
   endtask

   task automatic test_regin0;
      sb_t e;
      trk0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) tick(4'b1111, 1'b1);
         else        tick(4'b0000, 1'b0);
         if (k == 0) begin
            n_chk++;
            if (y0 !== 1'b1) begin
               n_fail++; $display("FAIL regin0_y got %b want 1", y0);
            end
            n_chk++;
            if (y1 !== 1'b0) begin
               n_fail++; $display("FAIL regin1_not_yet got %b want 0", y1);
            end
         end
         while (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front(); n_chk++;
            if (out1 !== e.exp) begin
               n_fail++; $display("FAIL regin dut a=%b got %b want %b", e.v, out1, e.exp);
            end
         end
         while (q0.size() != 0 && q0[0].due == cyc) begin
            e = q0.pop_front(); n_chk++;
            if (out0 !== e.exp) begin
               n_fail++; $display("FAIL regin dut0 a=%b got %b want %b", e.v, out0, e.exp);
            end
         end
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      trk0   = 1'b0;
      test_reset();
      test_async_reset();
      test_walk();
      test_ones();
      test_back_to_back();
      test_reset_midstream();
      test_regin0();
      n_chk++;
      if (q.size() != 0 || q0.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", q.size(), q0.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gates.md
Name: gates

Overview:
- Registered 4-input reduction-gate block.
- Samples a 4-bit input vector each clock and produces the AND-reduction on primary output y.
- Also provides companion OR/XOR/NAND/NOR/XNOR reductions of the same sample.
- Used as a small logic-function leaf feeding control/status decode.

Parameters:
- WIDTH, 4, number of input bits reduced; must be >= 1.
- REG_IN, 1, 1 = input vector registered before reduction (2-cycle latency); 0 = reduction taken directly from a (1-cycle latency).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  input vector; a[WIDTH-1] is the MSB.
- y  output  1  registered AND-reduction of a (all bits 1).
- y_or  output  1  registered OR-reduction (any bit 1).
- y_xor  output  1  registered XOR-reduction (odd parity).
- y_nand  output  1  registered NAND-reduction.
- y_nor  output  1  registered NOR-reduction.
- y_xnor  output  1  registered XNOR-reduction (even parity).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset assertion:
  - Immediately forces all six outputs to 0 and clears the input register (when REG_IN=1) to 0, independent of clk.
  - The reset value of y_nand/y_nor/y_xnor is 0 by decision; it is not the reduction of a zero vector.
- After reset release, the first rising edge begins normal operation. No outputs update on the release edge itself, except through the normal clocked path.
- REG_IN=1:
  - Edge n captures a into a_q.
  - Edge n+1 loads all outputs from reductions of a_q.
  - Latency is 2 cycles from a to outputs.
- REG_IN=0:
  - Edge n loads all outputs from reductions of a.
  - Latency is 1 cycle.
- Functions:
  - y = &a.
  - y_or = |a.
  - y_xor = ^a.
  - y_nand = ~y, y_nor = ~y_or, y_xnor = ~y_xor.
  - Complements are computed from the same sample, so they are always consistent in the same cycle.
- Throughput is one new vector per cycle; there is no handshake and no stall.
- Reset asserted mid-stream discards all in-flight samples. The first valid output after release reflects the first vector sampled after release.
- X/Z on a is not filtered; it propagates per standard reduction semantics.
- WIDTH=1: y = y_or = y_xor = a[0].

Decomposition:
- Package gates_pkg:
  - reduction-op enum (RED_AND, RED_OR, RED_XOR).
  - localparam default WIDTH=4.
  - function reduce(op, vec).
- Sub-module gates_reduce: purely combinational; takes vec[WIDTH-1:0] and returns the three base reductions.
- Top gates holds the optional input register, the output registers, and the complement logic.

Test Plan:
- Reset with rst_n=0 mid-cycle and a=4'b1111 → all outputs 0 immediately, with no clock edge required.
- REG_IN=1, apply a=0000,1000,0100,0010,0001 on successive cycles → y=0 throughout; y_or=0,1,1,1,1 and y_nor=1,0,0,0,0, each 2 cycles after the corresponding input.
- a=1111 → y=1, y_nand=0, y_xor=0, y_xnor=1; then a=1101 → y=0, y_xor=1, y_xnor=0.
- Exhaustive sweep of all 16 values of a with a back-to-back stream → every output matches the reference reduction with the fixed latency; y=1 only for 1111.
- Pulse rst_n low while a=1100,1010 are in flight → those samples never appear on the outputs; the first post-reset vector 1011 yields y_xor=1.
- REG_IN=0 build, a=1111 → y=1 on the next edge (1-cycle latency).
